// File: rtl/inst_encoder.sv
// inst_encoder: boot-time program writer. Accepts ADDI/ADD/SUB/END micro-op
// commands over a valid/ready handshake, encodes each into an RV32I word and
// writes it to consecutive instruction-memory word addresses starting at
// BASE_ADDR. A program ends with a NOP (addi x0,x0,0), written either for an
// END command or in place of a command that would take the last slot.
// Optional build macro: ENC_X0_FILTER_EN drops non-END commands with rd==x0.

// Runtime checks on the write port: the pending word is stable while the
// memory stalls, and nothing is written once the program is done.
module inst_encoder_chk (
   input logic        clk,
   input logic        rst,
   input logic        mem_wen,
   input logic        mem_ready,
   input logic [31:0] mem_waddr,
   input logic [31:0] mem_wdata,
   input logic        done
);

   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      (mem_wen && !mem_ready) |=> ($stable(mem_waddr) && $stable(mem_wdata)));

   a_done_quiet: assert property (@(posedge clk) disable iff (rst)
      done |-> !mem_wen);

endmodule

module inst_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 4096,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [1:0]       cmd_op_i,
   input  logic [4:0]       cmd_rd_i,
   input  logic [4:0]       cmd_rs1_i,
   input  logic [4:0]       cmd_rs2_i,
   input  logic [11:0]      cmd_imm_i,
   output logic             mem_wen_o,
   output logic [31:0]      mem_waddr_o,
   output logic [31:0]      mem_wdata_o,
   input  logic             mem_ready_i,
   output logic [CNT_W-1:0] inst_cnt_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             ovf_o
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'b00,
      ST_DRAIN = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   localparam logic [1:0]       OP_ADDI   = 2'b00;
   localparam logic [1:0]       OP_ADD    = 2'b01;
   localparam logic [1:0]       OP_SUB    = 2'b10;
   localparam logic [1:0]       OP_END    = 2'b11;
   localparam logic [31:0]      NOP_WORD  = 32'h0000_0013;
   localparam logic [31:0]      WORD_STEP = 32'h0000_0004;
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   // Slot index of the last word a program may occupy (reserved for the NOP).
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

   // RV32I encoding of one micro-op; END maps to the canonical NOP.
   function automatic logic [31:0] encode_cmd(
      input logic [1:0]  op,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [11:0] imm
   );
      logic [31:0] word;
      case (op)
         OP_ADDI: word = {imm, rs1, 3'b000, rd, 7'b0010011};
         OP_ADD:  word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
         OP_SUB:  word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
         default: word = NOP_WORD;
      endcase
      return word;
   endfunction

   state_t           state_r;
   state_t           state_next_s;
   logic             wen_r;
   logic             wen_next_s;
   logic [31:0]      waddr_r;
   logic [31:0]      waddr_next_s;
   logic [31:0]      wdata_r;
   logic [31:0]      wdata_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic             ovf_r;
   logic             ovf_next_s;
   logic             done_r;
   logic             done_next_s;
   logic             busy_r;
   logic             busy_next_s;

   logic             ready_s;
   logic             accept_s;
   logic             write_done_s;
   logic             drop_s;
   logic [CNT_W-1:0] slot_s;

   // Commands that produce no write at all (x0 destinations when filtering).
`ifdef ENC_X0_FILTER_EN
   assign drop_s = (cmd_op_i != OP_END) && (cmd_rd_i == 5'd0);
`else
   assign drop_s = 1'b0;
`endif

   // A new command can be taken whenever the output register is free or is
   // being emptied this very cycle, which gives one word per cycle streaming.
   assign ready_s      = (state_r == ST_LOAD) && (!wen_r || mem_ready_i);
   assign accept_s     = cmd_valid_i && ready_s;
   assign write_done_s = wen_r && mem_ready_i;
   // Slot the accepted command would occupy: completed words plus the one
   // still sitting in the output register (which completes this cycle).
   assign slot_s       = wen_r ? (cnt_r + CNT_ONE) : cnt_r;

   // Next-state, output-register and counter logic for the LOAD/DRAIN/DONE flow.
   always_comb begin
      state_next_s = state_r;
      if (write_done_s) begin
         wen_next_s   = 1'b0;
         waddr_next_s = waddr_r + WORD_STEP;
         cnt_next_s   = cnt_r + CNT_ONE;
      end else begin
         wen_next_s   = wen_r;
         waddr_next_s = waddr_r;
         cnt_next_s   = cnt_r;
      end
      wdata_next_s = wdata_r;
      ovf_next_s   = ovf_r;

      case (state_r)
         ST_LOAD: begin
            if (accept_s) begin
               if (cmd_op_i == OP_END) begin
                  wen_next_s   = 1'b1;
                  wdata_next_s = NOP_WORD;
                  state_next_s = ST_DRAIN;
               end else if (drop_s) begin
                  state_next_s = ST_LOAD;
               end else if (slot_s == LAST_SLOT) begin
                  wen_next_s   = 1'b1;
                  wdata_next_s = NOP_WORD;
                  ovf_next_s   = 1'b1;
                  state_next_s = ST_DRAIN;
               end else begin
                  wen_next_s   = 1'b1;
                  wdata_next_s = encode_cmd(cmd_op_i, cmd_rd_i, cmd_rs1_i,
                                            cmd_rs2_i, cmd_imm_i);
               end
            end else begin
               state_next_s = ST_LOAD;
            end
         end
         ST_DRAIN: begin
            if (!wen_r || write_done_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            if (start_i) begin
               state_next_s = ST_LOAD;
               wen_next_s   = 1'b0;
               waddr_next_s = BASE_ADDR;
               cnt_next_s   = CNT_ZERO;
               ovf_next_s   = 1'b0;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: begin
            state_next_s = ST_LOAD;
            wen_next_s   = 1'b0;
         end
      endcase

      done_next_s = (state_next_s == ST_DONE);
      busy_next_s = (state_next_s != ST_DONE) && wen_next_s;
   end

   // State, output register and status flags, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_LOAD;
         wen_r   <= 1'b0;
         waddr_r <= BASE_ADDR;
         wdata_r <= 32'h0000_0000;
         cnt_r   <= CNT_ZERO;
         ovf_r   <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         wen_r   <= wen_next_s;
         waddr_r <= waddr_next_s;
         wdata_r <= wdata_next_s;
         cnt_r   <= cnt_next_s;
         ovf_r   <= ovf_next_s;
         done_r  <= done_next_s;
         busy_r  <= busy_next_s;
      end
   end

   assign cmd_ready_o = ready_s;
   assign mem_wen_o   = wen_r;
   assign mem_waddr_o = waddr_r;
   assign mem_wdata_o = wdata_r;
   assign inst_cnt_o  = cnt_r;
   assign ovf_o       = ovf_r;
   assign done_o      = done_r;
   assign busy_o      = busy_r;

   inst_encoder_chk u_chk (
      .clk       (clk),
      .rst       (rst),
      .mem_wen   (wen_r),
      .mem_ready (mem_ready_i),
      .mem_waddr (waddr_r),
      .mem_wdata (wdata_r),
      .done      (done_r)
   );

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: directed scenarios with literal expectations,
// then randomized programs checked every cycle against a program-level model
// (expected write list built from slot index and the RV32I field layout).
module tb_inst_encoder;

   localparam int          DEPTH = 6;
   localparam int          CNT_W = 16;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i;
   logic             cmd_valid_i;
   logic             cmd_ready_o;
   logic [1:0]       cmd_op_i;
   logic [4:0]       cmd_rd_i;
   logic [4:0]       cmd_rs1_i;
   logic [4:0]       cmd_rs2_i;
   logic [11:0]      cmd_imm_i;
   logic             mem_wen_o;
   logic [31:0]      mem_waddr_o;
   logic [31:0]      mem_wdata_o;
   logic             mem_ready_i;
   logic [CNT_W-1:0] inst_cnt_o;
   logic             busy_o;
   logic             done_o;
   logic             ovf_o;

   inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_op_i    (cmd_op_i),
      .cmd_rd_i    (cmd_rd_i),
      .cmd_rs1_i   (cmd_rs1_i),
      .cmd_rs2_i   (cmd_rs2_i),
      .cmd_imm_i   (cmd_imm_i),
      .mem_wen_o   (mem_wen_o),
      .mem_waddr_o (mem_waddr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ready_i (mem_ready_i),
      .inst_cnt_o  (inst_cnt_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .ovf_o       (ovf_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit rand_ready = 1'b0;

   // Program-level model state
   bit          m_valid = 1'b0;
   int          m_slot  = 0;
   int          m_cnt   = 0;
   bit          m_fin   = 1'b0;
   bit          m_ovf   = 1'b0;
   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // RV32I word from the instruction field layout, by shift-and-or.
   function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1,
                                            input int rs2, input int imm);
      logic [31:0] w;
      case (op)
         0:       w = 32'((imm << 20) | (rs1 << 15) | (rd << 7) | 32'h13);
         1:       w = 32'((rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33);
         2:       w = 32'h4000_0000 | 32'((rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33);
         default: w = 32'h0000_0013;
      endcase
      return w;
   endfunction

   function automatic bit ref_drop(input int op, input int rd);
`ifdef ENC_X0_FILTER_EN
      return (op != 3) && (rd == 0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_clear();
      m_slot = 0;
      m_cnt  = 0;
      m_fin  = 1'b0;
      m_ovf  = 1'b0;
      q_addr.delete();
      q_data.delete();
   endtask

   // Compare DUT against the model mid-cycle, then apply this cycle's events.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("wen", 32'(mem_wen_o), 32'(q_addr.size() != 0));
         if (q_addr.size() != 0) begin
            chk("waddr", mem_waddr_o, q_addr[0]);
            chk("wdata", mem_wdata_o, q_data[0]);
         end
         chk("busy", 32'(busy_o), 32'(q_addr.size() != 0));
         chk("done", 32'(done_o), 32'(m_fin && q_addr.size() == 0));
         chk("ready", 32'(cmd_ready_o), 32'(!m_fin && (q_addr.size() == 0 || mem_ready_i)));
         chk("cnt", 32'(inst_cnt_o), 32'(m_cnt));
         chk("ovf", 32'(ovf_o), 32'(m_ovf));
      end
      if (rst) begin
         model_clear();
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (start_i && m_fin && q_addr.size() == 0) begin
            model_clear();
         end else begin
            if (q_addr.size() != 0 && mem_ready_i) begin
               void'(q_addr.pop_front());
               void'(q_data.pop_front());
               m_cnt++;
            end
            if (cmd_valid_i && cmd_ready_o && !m_fin) begin
               if (int'(cmd_op_i) == 3) begin
                  q_addr.push_back(BASE + 32'(4 * m_slot));
                  q_data.push_back(32'h0000_0013);
                  m_slot++;
                  m_fin = 1'b1;
               end else if (ref_drop(int'(cmd_op_i), int'(cmd_rd_i))) begin
                  m_fin = m_fin;
               end else if (m_slot == DEPTH - 1) begin
                  q_addr.push_back(BASE + 32'(4 * m_slot));
                  q_data.push_back(32'h0000_0013);
                  m_slot++;
                  m_fin = 1'b1;
                  m_ovf = 1'b1;
               end else begin
                  q_addr.push_back(BASE + 32'(4 * m_slot));
                  q_data.push_back(ref_word(int'(cmd_op_i), int'(cmd_rd_i), int'(cmd_rs1_i),
                                            int'(cmd_rs2_i), int'(cmd_imm_i)));
                  m_slot++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) mem_ready_i = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [11:0] imm);
      bit got;
      got = 1'b0;
      cmd_op_i    = op;
      cmd_rd_i    = rd;
      cmd_rs1_i   = rs1;
      cmd_rs2_i   = rs2;
      cmd_imm_i   = imm;
      cmd_valid_i = 1'b1;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge clk);
         if (cmd_ready_o) got = 1'b1;
         tick();
      end
      cmd_valid_i = 1'b0;
      if (!got) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done();
      for (int t = 0; t < 200 && !done_o; t++) tick();
      if (!done_o) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; cmd_valid_i = 1'b0; mem_ready_i = 1'b1;
      cmd_op_i = 2'd0; cmd_rd_i = 5'd0; cmd_rs1_i = 5'd0; cmd_rs2_i = 5'd0; cmd_imm_i = 12'd0;
      repeat (3) tick();
      chk("rst_wen", 32'(mem_wen_o), 32'd0);
      chk("rst_addr", mem_waddr_o, 32'h0000_0000);
      chk("rst_data", mem_wdata_o, 32'h0000_0000);
      chk("rst_cnt", 32'(inst_cnt_o), 32'd0);
      chk("rst_flags", {29'd0, done_o, ovf_o, busy_o}, 32'd0);
      rst = 1'b0;
      tick();

      // Single ADDI
      send(2'b00, 5'd1, 5'd0, 5'd0, 12'd5);
      chk("t1_data", mem_wdata_o, 32'h0050_0093);
      chk("t1_addr", mem_waddr_o, 32'h0000_0000);
      tick();
      chk("t1_cnt", 32'(inst_cnt_o), 32'd1);

      // ADD then SUB back to back
      send(2'b01, 5'd3, 5'd1, 5'd2, 12'd0);
      chk("t2_add", mem_wdata_o, 32'h0020_81B3);
      chk("t2_add_addr", mem_waddr_o, 32'h0000_0004);
      send(2'b10, 5'd3, 5'd1, 5'd2, 12'd0);
      chk("t2_sub", mem_wdata_o, 32'h4020_81B3);
      chk("t2_sub_addr", mem_waddr_o, 32'h0000_0008);
      chk("t2_cnt", 32'(inst_cnt_o), 32'd2);

      // Memory stall for three cycles
      mem_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_addr", mem_waddr_o, 32'h0000_0008);
         chk("t4_data", mem_wdata_o, 32'h4020_81B3);
         chk("t4_ready", 32'(cmd_ready_o), 32'd0);
      end
      mem_ready_i = 1'b1;
      tick();
      chk("t4_cnt", 32'(inst_cnt_o), 32'd3);

      // Negative immediate, then END
      send(2'b00, 5'd1, 5'd1, 5'd0, 12'hFFF);
      chk("t3_addi", mem_wdata_o, 32'hFFF0_8093);
      send(2'b11, 5'd0, 5'd0, 5'd0, 12'd0);
      chk("t3_end", mem_wdata_o, 32'h0000_0013);
      chk("t3_end_addr", mem_waddr_o, 32'h0000_0010);
      tick();
      chk("t3_done", 32'(done_o), 32'd1);
      chk("t3_ready", 32'(cmd_ready_o), 32'd0);
      pulse_start();
      chk("t3_restart_cnt", 32'(inst_cnt_o), 32'd0);

      // Capacity overflow: the last slot takes the NOP
      for (int i = 0; i < DEPTH; i++) send(2'b00, 5'd2, 5'd2, 5'd0, 12'(i));
      chk("t5_nop", mem_wdata_o, 32'h0000_0013);
      chk("t5_nop_addr", mem_waddr_o, 32'(4 * (DEPTH - 1)));
      chk("t5_ovf", 32'(ovf_o), 32'd1);
      tick();
      chk("t5_done", 32'(done_o), 32'd1);
      pulse_start();
      chk("t5_clr", {31'd0, ovf_o} | 32'(inst_cnt_o), 32'd0);
      send(2'b00, 5'd2, 5'd0, 5'd0, 12'd9);
      chk("t5_addr0", mem_waddr_o, 32'h0000_0000);
      tick();

      // Reset in the middle of a stalled write
      mem_ready_i = 1'b0;
      send(2'b00, 5'd4, 5'd0, 5'd0, 12'd7);
      tick();
      rst = 1'b1;
      tick();
      chk("t6_wen", 32'(mem_wen_o), 32'd0);
      chk("t6_cnt", 32'(inst_cnt_o), 32'd0);
      rst = 1'b0;
      mem_ready_i = 1'b1;
      tick();

      // Write to x0
      send(2'b00, 5'd0, 5'd0, 5'd0, 12'd1);
`ifdef ENC_X0_FILTER_EN
      chk("t6_x0_wen", 32'(mem_wen_o), 32'd0);
      tick();
      chk("t6_x0_cnt", 32'(inst_cnt_o), 32'd0);
`else
      chk("t6_x0_data", mem_wdata_o, 32'h0010_0013);
      tick();
      chk("t6_x0_cnt", 32'(inst_cnt_o), 32'd1);
`endif

      // Randomized programs
      rand_ready = 1'b1;
      for (int p = 0; p < 40; p++) begin
         for (int g = 0; g < 50 && !m_fin; g++) begin
            if ($urandom_range(0, 3) == 0) tick();
            if ($urandom_range(0, 7) == 0) pulse_start();
            if (p == 17 && g == 2) begin
               rst = 1'b1;
               tick();
               rst = 1'b0;
            end
            send(($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 12'($urandom_range(0, 4095)));
         end
         if (!m_fin) send(2'b11, 5'd0, 5'd0, 5'd0, 12'd0);
         wait_done();
         pulse_start();
      end
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
